// File: rtl/add_cla_pipe_if.sv
// Operand/result bus of the pipelined CLA adder.
// The slave modport is the adder's view; the master modport is the producer/consumer side.
interface add_cla_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/add_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit lookahead segment per stage,
// carry registered between stages, global stall when the result is not taken.
module add_cla_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic         clk,
  input  logic         rst,
  add_cla_pipe_if.slave bus
);

  localparam int NSEG = WIDTH / SEG;
  localparam int NGRP = SEG / 4;

  generate
    if ((SEG < 4) || ((SEG % 4) != 0) || ((WIDTH % SEG) != 0)) begin : g_bad_params
      $error("add_cla_pipe: WIDTH must be a multiple of SEG, and SEG a multiple of 4");
    end
  endgenerate

  // Returns {carry into segment MSB, carry out, sum}; carries are flattened lookahead terms.
  function automatic logic [SEG+1:0] claSeg(input logic [SEG-1:0] x,
                                            input logic [SEG-1:0] y,
                                            input logic           ci);
    logic [SEG-1:0]  g;
    logic [SEG-1:0]  p;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] gp;
    logic [NGRP:0]   gc;
    logic [SEG:0]    c;
    logic            term;
    g  = x & y;
    p  = x ^ y;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | ((&p[4*j+2 +: 2]) & g[4*j+1])
            | ((&p[4*j+1 +: 3]) & g[4*j]);
    end
    for (int j = 0; j <= NGRP; j++) begin
      term = ci;
      for (int m = 0; m < j; m++) term &= gp[m];
      gc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term &= gp[m];
        gc[j] |= term;
      end
    end
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < 4; i++) begin
        term = gc[j];
        for (int m = 0; m < i; m++) term &= p[4*j+m];
        c[4*j+i] = term;
        for (int n = 0; n < i; n++) begin
          term = g[4*j+n];
          for (int m = n + 1; m < i; m++) term &= p[4*j+m];
          c[4*j+i] |= term;
        end
      end
    end
    c[SEG] = gc[NGRP];
    return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic [NSEG-1:0]  valid_q;
  logic [NSEG-1:0]  valid_d;
  logic             carry_q  [NSEG];
  logic             carry_d  [NSEG];
  logic [WIDTH-1:0] aSkew_q  [NSEG];
  logic [WIDTH-1:0] aSkew_d  [NSEG];
  logic [WIDTH-1:0] bSkew_q  [NSEG];
  logic [WIDTH-1:0] bSkew_d  [NSEG];
  logic [WIDTH-1:0] sumSeg_q [NSEG];
  logic [WIDTH-1:0] sumSeg_d [NSEG];
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] aSrc [NSEG];
  logic [WIDTH-1:0] bSrc [NSEG];
  logic [WIDTH-1:0] sSrc [NSEG];
  logic             cSrc [NSEG];
  logic [NSEG-1:0]  vSrc;
  logic             stall;
  logic             advance;

  assign stall   = valid_q[NSEG-1] & ~bus.out_ready;
  assign advance = ~stall;

  // Stage 0 takes the preprocessed operands; later stages take the previous stage's registers.
  always_comb begin
    aSrc[0] = bus.a;
    bSrc[0] = bus.op_sub ? ~bus.b : bus.b;
    cSrc[0] = bus.cin ^ bus.op_sub;
    sSrc[0] = '0;
    vSrc[0] = bus.in_valid;
    for (int k = 1; k < NSEG; k++) begin
      aSrc[k] = aSkew_q[k-1];
      bSrc[k] = bSkew_q[k-1];
      cSrc[k] = carry_q[k-1];
      sSrc[k] = sumSeg_q[k-1];
      vSrc[k] = valid_q[k-1];
    end
  end

  always_comb begin
    logic [SEG+1:0] segRes;
    segRes  = '0;
    valid_d = vSrc;
    cout_d  = 1'b0;
    ovf_d   = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      segRes                       = claSeg(aSrc[k][k*SEG +: SEG], bSrc[k][k*SEG +: SEG], cSrc[k]);
      aSkew_d[k]                   = aSrc[k];
      bSkew_d[k]                   = bSrc[k];
      carry_d[k]                   = segRes[SEG];
      sumSeg_d[k]                  = sSrc[k];
      sumSeg_d[k][k*SEG +: SEG]    = segRes[SEG-1:0];
      if (k == NSEG - 1) begin
        cout_d = segRes[SEG];
        ovf_d  = segRes[SEG+1] ^ segRes[SEG];
      end
    end
    zero_d = (sumSeg_d[NSEG-1] == '0);
  end

  // Every pipeline register, valid bits included, freezes together while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        carry_q[k]  <= 1'b0;
        aSkew_q[k]  <= '0;
        bSkew_q[k]  <= '0;
        sumSeg_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      for (int k = 0; k < NSEG; k++) begin
        carry_q[k]  <= carry_d[k];
        aSkew_q[k]  <= aSkew_d[k];
        bSkew_q[k]  <= bSkew_d[k];
        sumSeg_q[k] <= sumSeg_d[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_q[NSEG-1];
  assign bus.sum       = sumSeg_q[NSEG-1];
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_add_cla_pipe.sv
// Self-checking bench for add_cla_pipe: vector table, scoreboard queue, backpressure,
// mid-flight reset, and latency checks on three parameterisations.
module tb_add_cla_pipe;

  localparam int W    = 32;
  localparam int S    = 8;
  localparam int NSEG = W / S;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_cla_pipe_if #(.WIDTH(W))  bus   ();
  add_cla_pipe_if #(.WIDTH(16)) bus16 ();
  add_cla_pipe_if #(.WIDTH(8))  bus8  ();

  add_cla_pipe #(.WIDTH(W),  .SEG(S)) dut   (.clk(clk), .rst(rst), .bus(bus));
  add_cla_pipe #(.WIDTH(16), .SEG(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  add_cla_pipe #(.WIDTH(8),  .SEG(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acceptCyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         opSub;
    logic [W-1:0] expSum;
    logic         expCout;
    logic         expOvf;
    logic         expZero;
  } vec_t;

  exp_t sbQ[$];
  exp_t head;
  vec_t vecs [11];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cyc         = 0;
  int   lastLatency = -1;
  bit   monEnable   = 1'b0;
  bit   randomReady = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic opSub);
    exp_t         e;
    logic [W-1:0] bEff;
    logic [W:0]   full;
    bEff        = opSub ? ~b : b;
    full        = {1'b0, a} + {1'b0, bEff} + {{W{1'b0}}, cin ^ opSub};
    e.sum       = full[W-1:0];
    e.cout      = full[W];
    e.ovf       = (a[W-1] == bEff[W-1]) && (e.sum[W-1] != a[W-1]);
    e.zero      = (e.sum == '0);
    e.acceptCyc = 0;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (randomReady) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard side: compare whatever sits at the output against the oldest outstanding result.
  always @(negedge clk) begin
    if (monEnable && !rst) begin
      checkOutput("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (bus.out_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected out_valid", 1, 0);
        end else begin
          head = sbQ[0];
          checkOutput("sum", bus.sum, head.sum);
          checkOutput("cout", bus.cout, head.cout);
          checkOutput("ovf", bus.ovf, head.ovf);
          checkOutput("zero", bus.zero, head.zero);
          if (bus.out_ready) begin
            lastLatency = cyc - head.acceptCyc;
            void'(sbQ.pop_front());
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic opSub, input exp_t e);
    bit accepted = 1'b0;
    int waitCyc  = 0;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.op_sub   = opSub;
    bus.in_valid = 1'b1;
    while (!accepted && waitCyc < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted    = 1'b1;
        e.acceptCyc = cyc;
        sbQ.push_back(e);
      end
      @(posedge clk);
      #1;
      waitCyc++;
    end
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.cin      = 1'($urandom);
    bus.op_sub   = 1'($urandom);
    if (!accepted) checkOutput("accept timeout", 0, 1);
  endtask

  task automatic applyVec(input vec_t v);
    exp_t e;
    e.sum       = v.expSum;
    e.cout      = v.expCout;
    e.ovf       = v.expOvf;
    e.zero      = v.expZero;
    e.acceptCyc = 0;
    applyStimulus(v.a, v.b, v.cin, v.opSub, e);
  endtask

  task automatic applyModel(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic opSub);
    applyStimulus(a, b, cin, opSub, model(a, b, cin, opSub));
  endtask

  task automatic drain();
    int n = 0;
    while ((sbQ.size() != 0 || bus.out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) checkOutput("drain timeout", 64'(sbQ.size()), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int           lat;

    vecs[0]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000002, 32'h00000002, 1'b0, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h00000003, 32'h00000003, 1'b0, 1'b0, 32'h00000006, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b0, 32'h22222221, 1'b0, 1'b0, 1'b0};

    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.cin        = 1'b0;
    bus.op_sub     = 1'b0;
    bus.out_ready  = 1'b0;
    bus16.in_valid = 1'b0;
    bus16.a        = '0;
    bus16.b        = '0;
    bus16.cin      = 1'b0;
    bus16.op_sub   = 1'b0;
    bus16.out_ready = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.cin       = 1'b0;
    bus8.op_sub    = 1'b0;
    bus8.out_ready = 1'b1;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset sum", bus.sum, 0);
    checkOutput("reset cout", bus.cout, 0);
    checkOutput("reset ovf", bus.ovf, 0);
    checkOutput("reset zero", bus.zero, 0);
    checkOutput("reset in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    monEnable     = 1'b1;
    bus.out_ready = 1'b1;

    // Carry ripples across every stage; latency must equal the stage count.
    applyVec(vecs[0]);
    drain();
    checkOutput("latency w32", 64'(lastLatency), 64'(NSEG));

    // Table applied back to back, so results stream on consecutive cycles.
    for (int i = 0; i < 11; i++) applyVec(vecs[i]);
    drain();

    // Backpressure: results pile up behind an unready consumer.
    bus.out_ready = 1'b0;
    applyModel(32'h0000000A, 32'h00000014, 1'b0, 1'b0);
    applyModel(32'h00001000, 32'h00000001, 1'b0, 1'b1);
    applyModel(32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0);
    repeat (NSEG + 2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("stall out_valid", bus.out_valid, 1);
    checkOutput("stall in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    // Random traffic with random backpressure and idle gaps.
    randomReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 4) == 0) ra = 32'hFFFFFFFF;
      if ($urandom_range(0, 4) == 0) rb = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'h80000000;
      applyModel(ra, rb, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    randomReady   = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    // Reset with one result stalled at the output and another still in flight.
    bus.out_ready = 1'b0;
    applyModel(32'h00001234, 32'h00001111, 1'b0, 1'b0);
    applyModel(32'h00000100, 32'h00000001, 1'b1, 1'b1);
    repeat (NSEG) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("pre-reset out_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset out_valid", bus.out_valid, 0);
    checkOutput("async reset sum", bus.sum, 0);
    checkOutput("async reset cout", bus.cout, 0);
    checkOutput("async reset zero", bus.zero, 0);
    sbQ.delete();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2 * NSEG + 2; i++) begin
      @(negedge clk);
      checkOutput("stale out_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Same all-ones carry chain on a 4-stage 16-bit pipe.
    bus16.a        = 16'hFFFF;
    bus16.b        = 16'h0000;
    bus16.cin      = 1'b1;
    bus16.op_sub   = 1'b0;
    bus16.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("w16 in_ready", bus16.in_ready, 1);
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency w16", 64'(lat), 4);
    checkOutput("w16 sum", bus16.sum, 0);
    checkOutput("w16 cout", bus16.cout, 1);
    checkOutput("w16 ovf", bus16.ovf, 0);
    checkOutput("w16 zero", bus16.zero, 1);

    // And on a single-stage 8-bit adder.
    bus8.a        = 8'hFF;
    bus8.b        = 8'h00;
    bus8.cin      = 1'b1;
    bus8.op_sub   = 1'b0;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("w8 in_ready", bus8.in_ready, 1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency w8", 64'(lat), 1);
    checkOutput("w8 sum", bus8.sum, 0);
    checkOutput("w8 cout", bus8.cout, 1);
    checkOutput("w8 ovf", bus8.ovf, 0);
    checkOutput("w8 zero", bus8.zero, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
